// File: rtl/uart_pkg.sv
// uart_pkg
//   Types shared by the UART receive and transmit controllers.
//   rx_state_t : receive FSM state encoding.
package uart_pkg;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP_1,
        RX_STOP_2
    } rx_state_t;

endpackage

// File: rtl/uart_receiver_if.sv
// uart_receiver_if
//   Push-side handshake between the UART receiver and the RX queue.
//   master : receiver  (drives push strobe, word and flags; sees queue full)
//   slave  : RX queue  (drives queue full; sees push strobe, word and flags)
interface uart_receiver_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  rx_queue_full;
    logic                  rx_queue_we;
    logic [DATA_WIDTH-1:0] rx_data;
    logic                  rx_parity_err;
    logic                  rx_frame_err;
    logic                  rx_overrun_err;

    modport master (
        input  rx_queue_full,
        output rx_queue_we,
        output rx_data,
        output rx_parity_err,
        output rx_frame_err,
        output rx_overrun_err
    );

    modport slave (
        output rx_queue_full,
        input  rx_queue_we,
        input  rx_data,
        input  rx_parity_err,
        input  rx_frame_err,
        input  rx_overrun_err
    );
endinterface

// File: rtl/uart_rx_sync.sv
// uart_rx_sync
//   Two-flop synchronizer for the asynchronous rx line. Resets to 1 so that
//   the line looks idle and no false start edge is seen after reset.
//   clk   : system clock
//   reset : synchronous, active-high
//   rx    : asynchronous serial input
//   rx_s  : synchronized rx
module uart_rx_sync (
    input  logic clk,
    input  logic reset,
    input  logic rx,
    output logic rx_s
);
    logic rx_meta;

    always_ff @(posedge clk) begin
        if (reset) begin
            rx_meta <= 1'b1;
            rx_s    <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_s    <= rx_meta;
        end
    end
endmodule

// File: rtl/uart_receiver.sv
// uart_receiver
//   UART receive path: deserializes rx into DATA_WIDTH-bit words (LSB first),
//   checks optional parity and one or two stop bits, and pushes each word with
//   its error flags into the RX queue. All timing runs off rx_clk_en.
//   clk, reset        : system clock, synchronous active-high reset
//   rx_clk_en         : oversampling tick, OVERSAMPLE per bit period
//   rx                : asynchronous serial line, idles high
//   parity_en         : frame carries a parity bit
//   parity_odd        : 1 = odd parity, 0 = even
//   double_stop_bit   : two stop bits
//   rx_busy           : FSM is not in RX_IDLE
//   q (master)        : RX queue push port (we, data, parity/frame/overrun flags)
module uart_receiver
    import uart_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic clk,
    input  logic reset,
    input  logic rx_clk_en,
    input  logic rx,
    input  logic parity_en,
    input  logic parity_odd,
    input  logic double_stop_bit,
    output logic rx_busy,
    uart_receiver_if.master q
);
    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_WIDTH + 1);
    localparam logic [TW-1:0] TICK_MID  = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] TICK_LAST = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(DATA_WIDTH - 1);

    logic rx_s;
    logic rx_prev;

    rx_state_t             state_q, state_d;
    logic [TW-1:0]         tick_q, tick_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
    logic                  perr_q, perr_d;
    logic                  ferr_q, ferr_d;
    logic                  pen_q, pen_d;
    logic                  podd_q, podd_d;
    logic                  dstop_q, dstop_d;
    logic                  push;
    logic                  we_q, ovr_q;
    logic [DATA_WIDTH-1:0] data_q;
    logic [TW-1:0]         tick_nxt;

    uart_rx_sync u_sync (
        .clk   (clk),
        .reset (reset),
        .rx    (rx),
        .rx_s  (rx_s)
    );

    assign tick_nxt = (tick_q == TICK_LAST) ? '0 : tick_q + 1'b1;

    always_comb begin
        state_d = state_q;
        tick_d  = tick_q;
        bit_d   = bit_q;
        shreg_d = shreg_q;
        perr_d  = perr_q;
        ferr_d  = ferr_q;
        pen_d   = pen_q;
        podd_d  = podd_q;
        dstop_d = dstop_q;
        push    = 1'b0;
        if (rx_clk_en) begin
            tick_d = tick_nxt;
            unique case (state_q)
                RX_IDLE: begin
                    tick_d = '0;
                    // rx_prev holds rx_s from the previous tick, so a held-low
                    // line never produces a second start.
                    if (rx_prev && !rx_s) state_d = RX_START;
                end
                RX_START: begin
                    if (tick_q == TICK_MID) begin
                        if (!rx_s) begin
                            state_d = RX_DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                            perr_d  = 1'b0;
                            ferr_d  = 1'b0;
                            pen_d   = parity_en;
                            podd_d  = parity_odd;
                            dstop_d = double_stop_bit;
                        end else begin
                            state_d = RX_IDLE;
                        end
                    end
                end
                RX_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        shreg_d = {rx_s, shreg_q[DATA_WIDTH-1:1]};
                        bit_d   = bit_q + 1'b1;
                        if (bit_q == BIT_LAST) state_d = pen_q ? RX_PARITY : RX_STOP_1;
                    end
                end
                RX_PARITY: begin
                    if (tick_q == TICK_LAST) begin
                        perr_d  = ((^shreg_q) ^ rx_s) != podd_q;
                        state_d = RX_STOP_1;
                    end
                end
                RX_STOP_1: begin
                    if (tick_q == TICK_LAST) begin
                        ferr_d = ferr_q | ~rx_s;
                        if (dstop_q) begin
                            state_d = RX_STOP_2;
                        end else begin
                            push    = 1'b1;
                            state_d = RX_IDLE;
                        end
                    end
                end
                RX_STOP_2: begin
                    if (tick_q == TICK_LAST) begin
                        ferr_d  = ferr_q | ~rx_s;
                        push    = 1'b1;
                        state_d = RX_IDLE;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= RX_IDLE;
            tick_q  <= '0;
            bit_q   <= '0;
            shreg_q <= '0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            pen_q   <= 1'b0;
            podd_q  <= 1'b0;
            dstop_q <= 1'b0;
            rx_prev <= 1'b1;
            we_q    <= 1'b0;
            ovr_q   <= 1'b0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            tick_q  <= tick_d;
            bit_q   <= bit_d;
            shreg_q <= shreg_d;
            perr_q  <= perr_d;
            ferr_q  <= ferr_d;
            pen_q   <= pen_d;
            podd_q  <= podd_d;
            dstop_q <= dstop_d;
            if (rx_clk_en) rx_prev <= rx_s;
            we_q  <= push & ~q.rx_queue_full;
            ovr_q <= push & q.rx_queue_full;
            if (push) data_q <= shreg_q;
        end
    end

    assign q.rx_queue_we    = we_q;
    assign q.rx_overrun_err = ovr_q;
    assign q.rx_data        = data_q;
    assign q.rx_parity_err  = perr_q;
    assign q.rx_frame_err   = ferr_q;
    assign rx_busy          = (state_q != RX_IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver
//   Directed and randomized frames driven onto rx; pushes are captured by a
//   monitor and compared against expectations computed from the frame contents.
module tb_uart_receiver;
    localparam int OS = 16;
    localparam int DW = 8;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic rx_clk_en = 1'b1;
    logic rx = 1'b1;
    logic parity_en = 1'b0;
    logic parity_odd = 1'b0;
    logic double_stop_bit = 1'b0;
    logic rx_busy;

    uart_receiver_if #(.DATA_WIDTH(DW)) qif ();

    uart_receiver #(.DATA_WIDTH(DW), .OVERSAMPLE(OS)) dut (
        .clk             (clk),
        .reset           (reset),
        .rx_clk_en       (rx_clk_en),
        .rx              (rx),
        .parity_en       (parity_en),
        .parity_odd      (parity_odd),
        .double_stop_bit (double_stop_bit),
        .rx_busy         (rx_busy),
        .q               (qif.master)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int en_period = 1;
    int en_cnt = 0;
    int start_cyc = 0;
    int ov_cnt = 0;
    int ov_wide = 0;
    int busy_cnt = 0;
    logic ov_prev = 1'b0;

    logic [7:0] got_data[$];
    logic       got_perr[$];
    logic       got_ferr[$];
    int         got_lat[$];

    always @(posedge clk) cyc++;

    always @(negedge clk) begin
        rx_clk_en = (en_cnt % en_period == 0);
        en_cnt++;
    end

    always @(negedge clk) begin
        if (qif.rx_queue_we === 1'b1) begin
            got_data.push_back(qif.rx_data);
            got_perr.push_back(qif.rx_parity_err);
            got_ferr.push_back(qif.rx_frame_err);
            got_lat.push_back(cyc - start_cyc);
        end
        if (qif.rx_overrun_err === 1'b1) begin
            ov_cnt++;
            if (ov_prev) ov_wide++;
        end
        ov_prev = qif.rx_overrun_err;
        if (rx_busy === 1'b1) busy_cnt++;
    end

    initial begin
        #900_000;
        $display("FAIL watchdog: observed no finish, expected finish before time limit");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic hold_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            do @(posedge clk); while (rx_clk_en !== 1'b1);
        end
        #1;
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_we"},    32'(qif.rx_queue_we), 0);
        check({tag, "_data"},  32'(qif.rx_data), 0);
        check({tag, "_perr"},  32'(qif.rx_parity_err), 0);
        check({tag, "_ferr"},  32'(qif.rx_frame_err), 0);
        check({tag, "_ovr"},   32'(qif.rx_overrun_err), 0);
        check({tag, "_busy"},  32'(rx_busy), 0);
    endtask

    // Sends one frame and checks what it produced. The parity bit is the
    // correct one for d unless pflip; bad_stop drives the last stop bit low.
    task automatic send_frame(input string tag, input logic [7:0] d, input bit pen,
                              input bit podd, input bit dstop, input bit pflip,
                              input bit bad_stop, input bit exp_push);
        bit pbit, s1, s2, exp_perr, exp_ferr;
        int exp_lat;
        pbit = bit'($countones(d) % 2) ^ podd ^ pflip;
        s1 = dstop ? 1'b1 : !bad_stop;
        s2 = !bad_stop;
        exp_perr = pen && ((($countones(d) + int'(pbit)) % 2) != int'(podd));
        exp_ferr = !s1 || (dstop && !s2);
        // 3 clks to reach the FSM (2 sync flops + previous-level register),
        // then samples at mid-bit; last sample is the final stop bit.
        exp_lat = 3 + OS / 2 + OS * (DW + int'(pen) + 1 + int'(dstop));
        parity_en = pen;
        parity_odd = podd;
        double_stop_bit = dstop;
        rx = 1'b0;
        start_cyc = cyc;
        hold_ticks(OS);
        // Scramble config mid-frame; the frame must use the values latched at start.
        parity_en = 1'($urandom);
        parity_odd = 1'($urandom);
        double_stop_bit = 1'($urandom);
        for (int i = 0; i < DW; i++) begin
            rx = d[i];
            hold_ticks(OS);
        end
        if (pen) begin
            rx = pbit;
            hold_ticks(OS);
        end
        rx = s1;
        hold_ticks(OS);
        if (dstop) begin
            rx = s2;
            hold_ticks(OS);
        end
        if (exp_push) begin
            check({tag, "_push_count"}, 32'(got_data.size()), 1);
            if (got_data.size() > 0) begin
                check({tag, "_data"}, 32'(got_data.pop_front()), 32'(d));
                check({tag, "_perr"}, 32'(got_perr.pop_front()), 32'(exp_perr));
                check({tag, "_ferr"}, 32'(got_ferr.pop_front()), 32'(exp_ferr));
                if (en_period == 1) check({tag, "_latency"}, 32'(got_lat[0]), 32'(exp_lat));
                void'(got_lat.pop_front());
            end
        end else begin
            check({tag, "_no_push"}, 32'(got_data.size()), 0);
        end
        got_data.delete();
        got_perr.delete();
        got_ferr.delete();
        got_lat.delete();
    endtask

    initial begin
        int snap_busy, snap_ov;
        qif.rx_queue_full = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check_outputs_zero("reset");
        reset = 1'b0;
        hold_ticks(20);

        // 8N1 0xA5
        send_frame("t1_a5", 8'hA5, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t1_we_width", 32'(qif.rx_queue_we), 0);
        hold_ticks(4);

        // 8E1 0x3C with wrong parity, then 8O2 0x01 correct
        send_frame("t2_3c", 8'h3C, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1);
        send_frame("t2_01", 8'h01, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
        hold_ticks(4);

        // 4-tick glitch
        rx = 1'b0;
        hold_ticks(4);
        rx = 1'b1;
        check("t3_busy_start", 32'(rx_busy), 1);
        hold_ticks(4);
        check("t3_busy_pre_sample", 32'(rx_busy), 1);
        hold_ticks(6);
        check("t3_idle_after_sample", 32'(rx_busy), 0);
        check("t3_no_push", 32'(got_data.size()), 0);
        hold_ticks(10);

        // 0x55 with low stop bit, then break
        send_frame("t4_55", 8'h55, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        snap_busy = busy_cnt;
        hold_ticks(3 * 10 * OS);
        check("t4_break_busy", 32'(busy_cnt - snap_busy), 0);
        check("t4_break_push", 32'(got_data.size()), 0);
        rx = 1'b1;
        hold_ticks(OS);
        check("t4_release_busy", 32'(busy_cnt - snap_busy), 0);

        // Overrun
        snap_ov = ov_cnt;
        qif.rx_queue_full = 1'b1;
        send_frame("t5_7e", 8'h7E, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        check("t5_ovr_pulses", 32'(ov_cnt - snap_ov), 1);
        check("t5_ovr_width", 32'(ov_wide), 0);
        qif.rx_queue_full = 1'b0;
        hold_ticks(4);
        send_frame("t5_81", 8'h81, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        check("t5_no_extra_ovr", 32'(ov_cnt - snap_ov), 1);

        // Randomized frames, some back-to-back
        for (int k = 0; k < 8; k++) begin
            logic [7:0] d;
            bit pen, podd, dstop, pflip, bad;
            int gap;
            d = 8'($urandom);
            pen = 1'($urandom);
            podd = 1'($urandom);
            dstop = 1'($urandom);
            pflip = pen && ($urandom_range(3) == 0);
            bad = ($urandom_range(3) == 0);
            send_frame($sformatf("rnd%0d", k), d, pen, podd, dstop, pflip, bad, 1'b1);
            gap = bad ? 2 + $urandom_range(3) : $urandom_range(3);
            rx = 1'b1;
            if (gap > 0) hold_ticks(gap);
        end
        hold_ticks(4);

        // Reset mid-RX_DATA with a slow tick
        en_period = 3;
        hold_ticks(4);
        rx = 1'b0;
        hold_ticks(OS);
        rx = 1'b1;
        hold_ticks(OS);
        rx = 1'b1;
        hold_ticks(OS);
        rx = 1'b0;
        hold_ticks(OS);
        check("t6_busy_mid_data", 32'(rx_busy), 1);
        reset = 1'b1;
        rx = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        check_outputs_zero("t6_reset");
        reset = 1'b0;
        hold_ticks(20);
        check("t6_no_push", 32'(got_data.size()), 0);
        send_frame("t6_c3", 8'hC3, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        hold_ticks(4);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
